booth_r4_mul: RTL

Parametrised sequential radix-4 Booth multiplier, successor to the fixed-width radix-2 multiplier in the arithmetic lab set. It retires two multiplier bits per cycle and supports signed and unsigned operands selected per operation. It uses a start/busy/done handshake so that a controller or testbench can issue back-to-back products. The full 2·WIDTH product is held stable until the next accepted start.

---
 rtl/booth_pkg.sv | 31 +++
 rtl/booth_r4_enc.sv | 22 ++
 rtl/booth_r4_mul.sv | 132 +++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier.
//   state_t   : controller states
//   digit_t   : recoded Booth digit as {zero, neg, two}
//   calc_iw   : internal operand width (even, at least WIDTH+1)
//   calc_iter : number of radix-4 iterations (calc_iw/2)
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit magnitude is 0, 1 or 2; neg gives the sign.
    typedef struct packed {
        logic zero;
        logic neg;
        logic two;
    } digit_t;

    // One guard bit keeps both signed and unsigned operands positive-safe
    // as IW-bit two's-complement values; rounding up to even gives whole digits.
    function automatic int calc_iw(input int width);
        return (width % 2 == 0) ? width + 2 : width + 1;
    endfunction

    function automatic int calc_iter(input int width);
        return calc_iw(width) / 2;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder.
//   triple : {b[2i+1], b[2i], b[2i-1]}
//   digit  : {zero, neg, two} encoding a digit in {-2,-1,0,+1,+2}
module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0] triple,
    output digit_t     digit
);

    logic is_zero;
    logic is_neg;
    logic is_two;

    assign is_zero = (triple == 3'b000) || (triple == 3'b111);
    // 100, 101, 110 are the negative digits; 111 is zero.
    assign is_neg  = triple[2] && !(triple[1] && triple[0]);
    assign is_two  = (triple == 3'b011) || (triple == 3'b100);

    assign digit = {is_zero, is_neg, is_two};

endmodule

// File: rtl/booth_r4_mul.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation.
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   start       : request, accepted in IDLE or DONE
//   signed_mode : 1 = two's-complement operands, 0 = unsigned
//   a, b        : multiplicand / multiplier, captured on accept
//   busy        : high while iterating
//   done        : one-cycle pulse when c is updated
//   c           : 2*WIDTH-bit product, held until the next result
module booth_r4_mul
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] c
);

    localparam int IW   = calc_iw(WIDTH);
    localparam int ITER = calc_iter(WIDTH);
    localparam int AW   = IW + 2;      // room for +/-2M without overflow
    localparam int CW   = $clog2(ITER + 1);
    localparam int PW   = 2 * WIDTH;
    localparam int XW   = IW - WIDTH;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t         state_reg;
    state_t         state_next;
    logic [CW-1:0]  cnt_reg;
    logic [AW-1:0]  acc_reg;
    logic [IW-1:0]  mul_reg;
    logic [IW-1:0]  mcand_reg;
    logic           bm1_reg;
    logic [PW-1:0]  c_reg;
    logic           done_reg;

    logic           accept;
    logic [IW-1:0]  a_ext;
    logic [IW-1:0]  b_ext;
    digit_t         digit;
    logic [AW-1:0]  m_ext;
    logic [AW-1:0]  m_mag;
    logic [AW-1:0]  pp;
    logic [AW-1:0]  sum;

    // Sign bit is replicated only in signed mode, otherwise zero-filled.
    assign a_ext = {{XW{signed_mode & a[WIDTH-1]}}, a};
    assign b_ext = {{XW{signed_mode & b[WIDTH-1]}}, b};

    assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));

    booth_r4_enc u_enc (
        .triple ({mul_reg[1:0], bm1_reg}),
        .digit  (digit)
    );

    always_comb begin
        m_ext = {{2{mcand_reg[IW-1]}}, mcand_reg};
        m_mag = digit.two ? {m_ext[AW-2:0], 1'b0} : m_ext;
        pp    = '0;
        if (!digit.zero) begin
            pp = digit.neg ? -m_mag : m_mag;
        end
        sum = acc_reg + pp;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = CALC;
            CALC: if (cnt_reg == LAST) state_next = DONE;
            DONE: state_next = start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // {acc, mul, bm1} forms one shift register: each iteration adds the
    // digit multiple to the upper part and shifts the whole thing right by 2,
    // so the multiplier bits retire from the bottom as product bits enter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            acc_reg   <= '0;
            mul_reg   <= '0;
            mcand_reg <= '0;
            bm1_reg   <= 1'b0;
        end else if (accept) begin
            cnt_reg   <= '0;
            acc_reg   <= '0;
            mul_reg   <= b_ext;
            mcand_reg <= a_ext;
            bm1_reg   <= 1'b0;
        end else if (state_reg == CALC) begin
            acc_reg <= {{2{sum[AW-1]}}, sum[AW-1:2]};
            mul_reg <= {sum[1:0], mul_reg[IW-1:2]};
            bm1_reg <= mul_reg[1];
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    // The low 2*WIDTH bits of the 2*IW-bit product are exact in both modes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_reg    <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= (state_reg == DONE);
            if (state_reg == DONE) begin
                c_reg <= PW'({acc_reg[IW-1:0], mul_reg});
            end
        end
    end

    assign busy = (state_reg == CALC);
    assign done = done_reg;
    assign c    = c_reg;

endmodule
